// File: rtl/pixel_layer_mux.sv
// pixel_layer_mux
//   Registered N-channel pixel compositor for the VGA colour path. Each pixel,
//   the lowest-index visible channel wins. If no channel is visible,
//   bg_color is shown. During blanking the output is forced to black.
//   Enable and flash masks are double-buffered and load only on frame_start.
//   A frame counter drives the blink phase.
//
// Ports
//   clk          pixel clock, all state on rising edge
//   rst_n        synchronous active-low reset
//   pix_in       channel i colour at [i*WIDTH +: WIDTH]
//   pix_hit      bit i = channel i claims the current pixel
//   blank        1 = outside active video
//   frame_start  one-cycle pulse at frame start
//   en_mask      requested enable mask, sampled at frame_start
//   flash_mask   requested flash mask, sampled at frame_start
//   bg_color     colour shown when no channel wins
//   pix_out      registered composite colour
//   src_hit      registered, 1 = a channel won this pixel
//   src_idx      registered winning channel index (0 when src_hit=0)
//   flash_phase  flash phase, 0 = shown, 1 = hidden

// Per-channel visibility term
module pixel_layer_lane (
   input  logic hit,
   input  logic en,
   input  logic flash,
   input  logic phase,
   output logic vis
);
   assign vis = hit & en & ~(flash & phase);
endmodule

module pixel_layer_mux #(
   parameter  int WIDTH        = 12,
   parameter  int CHANNELS     = 4,
   parameter  int FLASH_FRAMES = 30,
   localparam int SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] pix_in,
   input  logic [CHANNELS-1:0]       pix_hit,
   input  logic                      blank,
   input  logic                      frame_start,
   input  logic [CHANNELS-1:0]       en_mask,
   input  logic [CHANNELS-1:0]       flash_mask,
   input  logic [WIDTH-1:0]          bg_color,
   output logic [WIDTH-1:0]          pix_out,
   output logic                      src_hit,
   output logic [SEL_W-1:0]          src_idx,
   output logic                      flash_phase
);
   localparam int FCNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

   logic [WIDTH-1:0]    pix_out_q, pix_out_d;
   logic                src_hit_q, src_hit_d;
   logic [SEL_W-1:0]    src_idx_q, src_idx_d;
   logic [CHANNELS-1:0] en_act_q, en_act_d;
   logic [CHANNELS-1:0] flash_act_q, flash_act_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   logic                flash_phase_q, flash_phase_d;

   logic [CHANNELS-1:0] vis;
   logic                win_found;
   logic [SEL_W-1:0]    win_idx;
   logic [WIDTH-1:0]    win_pix;

   // The current pixel sees the active (old) masks and phase. New values
   // are loaded on the frame_start edge and apply to the following pixel.
   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      pixel_layer_lane u_lane (
         .hit   (pix_hit[g]),
         .en    (en_act_q[g]),
         .flash (flash_act_q[g]),
         .phase (flash_phase_q),
         .vis   (vis[g])
      );
   end

   // Priority select. Scanning from the top index down lets a lower visible
   // index overwrite a higher one, so channel 0 ends up on top.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_pix   = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (vis[i]) begin
            win_found = 1'b1;
            win_idx   = SEL_W'(i);
            win_pix   = pix_in[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      pix_out_d     = bg_color;
      src_hit_d     = 1'b0;
      src_idx_d     = '0;
      en_act_d      = en_act_q;
      flash_act_d   = flash_act_q;
      fcnt_d        = fcnt_q;
      flash_phase_d = flash_phase_q;

      if (blank) begin
         pix_out_d = '0;
      end else if (win_found) begin
         pix_out_d = win_pix;
         src_hit_d = 1'b1;
         src_idx_d = win_idx;
      end

      if (frame_start) begin
         en_act_d    = en_mask;
         flash_act_d = flash_mask;
         // With FLASH_FRAMES=1 the terminal count is 0, so the phase
         // toggles on every frame_start.
         if (fcnt_q == FCNT_W'(FLASH_FRAMES - 1)) begin
            fcnt_d        = '0;
            flash_phase_d = ~flash_phase_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pix_out_q     <= '0;
         src_hit_q     <= 1'b0;
         src_idx_q     <= '0;
         en_act_q      <= '1;
         flash_act_q   <= '0;
         fcnt_q        <= '0;
         flash_phase_q <= 1'b0;
      end else begin
         pix_out_q     <= pix_out_d;
         src_hit_q     <= src_hit_d;
         src_idx_q     <= src_idx_d;
         en_act_q      <= en_act_d;
         flash_act_q   <= flash_act_d;
         fcnt_q        <= fcnt_d;
         flash_phase_q <= flash_phase_d;
      end
   end

   assign pix_out     = pix_out_q;
   assign src_hit     = src_hit_q;
   assign src_idx     = src_idx_q;
   assign flash_phase = flash_phase_q;

endmodule

// File: tb/tb_pixel_layer_mux.sv
// Testbench for pixel_layer_mux (CHANNELS=4, WIDTH=12, FLASH_FRAMES=2).
// Table vectors plus hand-written sequences. Expected outputs are queued at
// drive time and compared one cycle later.
module tb_pixel_layer_mux;
   localparam int W  = 12;
   localparam int CH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CH*W-1:0] pix_in;
   logic [CH-1:0] pix_hit;
   logic          blank;
   logic          frame_start;
   logic [CH-1:0] en_mask;
   logic [CH-1:0] flash_mask;
   logic [W-1:0]  bg_color;
   logic [W-1:0]  pix_out;
   logic          src_hit;
   logic [1:0]    src_idx;
   logic          flash_phase;

   pixel_layer_mux #(.WIDTH(W), .CHANNELS(CH), .FLASH_FRAMES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_in      (pix_in),
      .pix_hit     (pix_hit),
      .blank       (blank),
      .frame_start (frame_start),
      .en_mask     (en_mask),
      .flash_mask  (flash_mask),
      .bg_color    (bg_color),
      .pix_out     (pix_out),
      .src_hit     (src_hit),
      .src_idx     (src_idx),
      .flash_phase (flash_phase)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst_n;
      logic [CH*W-1:0] pix;
      logic [CH-1:0] hit;
      logic          blank;
      logic          fs;
      logic [CH-1:0] en;
      logic [CH-1:0] fl;
      logic [W-1:0]  bg;
      logic [W-1:0]  e_pix;
      logic          e_hit;
      logic [1:0]    e_idx;
      logic          e_phase;
   } vec_t;

   typedef struct {
      logic [W-1:0] pix;
      logic         hit;
      logic [1:0]   idx;
      logic         phase;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // ch3=0x0F0, ch2=0x555, ch1=0xF00, ch0=0x00F
   localparam logic [CH*W-1:0] PIX = {12'h0F0, 12'h555, 12'hF00, 12'h00F};

   function automatic vec_t mk(logic r, logic [CH-1:0] h, logic b, logic f,
                               logic [CH-1:0] e, logic [CH-1:0] fl, logic [W-1:0] bg,
                               logic [W-1:0] ep, logic eh, logic [1:0] ei, logic eph);
      vec_t v;
      v.rst_n = r; v.pix = PIX; v.hit = h; v.blank = b; v.fs = f;
      v.en = e; v.fl = fl; v.bg = bg;
      v.e_pix = ep; v.e_hit = eh; v.e_idx = ei; v.e_phase = eph;
      return v;
   endfunction

   task automatic apply(input vec_t v, input string name);
      exp_t e, got;
      rst_n = v.rst_n; pix_in = v.pix; pix_hit = v.hit; blank = v.blank;
      frame_start = v.fs; en_mask = v.en; flash_mask = v.fl; bg_color = v.bg;
      e.pix = v.e_pix; e.hit = v.e_hit; e.idx = v.e_idx; e.phase = v.e_phase;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = exp_q.pop_front();
         got.pix = pix_out; got.hit = src_hit; got.idx = src_idx; got.phase = flash_phase;
         if (got.pix !== e.pix || got.hit !== e.hit || got.idx !== e.idx || got.phase !== e.phase) begin
            n_bad++;
            $display("FAIL %s: got pix=%h hit=%b idx=%0d phase=%b, want pix=%h hit=%b idx=%0d phase=%b",
                     name, got.pix, got.hit, got.idx, got.phase, e.pix, e.hit, e.idx, e.phase);
         end
      end
   endtask

   // Compact helper for the hand-written sequences (no blank, fixed bg 0x456)
   task automatic seq(input logic r, input logic f, input logic [CH-1:0] h,
                      input logic [CH-1:0] e, input logic [CH-1:0] fl,
                      input logic [W-1:0] ep, input logic eh, input logic [1:0] ei,
                      input logic eph, input string name);
      apply(mk(r, h, 1'b0, f, e, fl, 12'h456, ep, eh, ei, eph), name);
   endtask

   vec_t tbl[$];

   initial begin
      vec_t v;
      rst_n = 1'b0; pix_in = '0; pix_hit = '0; blank = 1'b0; frame_start = 1'b0;
      en_mask = '0; flash_mask = '0; bg_color = '0;

      // reset with random inputs, including random frame_start
      for (int i = 0; i < 3; i++) begin
         v = mk(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                4'($urandom), 12'($urandom), 12'h000, 1'b0, 2'd0, 1'b0);
         v.pix = {$urandom, $urandom};
         tbl.push_back(v);
      end
      //               rst  hit     blk  fs   en       fl       bg       pix      hit  idx phase
      tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b1111, 4'b0000, 12'h123, 12'h123, 0, 0, 0)); // bg after reset
      tbl.push_back(mk(1, 4'b1010, 0, 0, 4'b1111, 4'b0000, 12'h123, 12'hF00, 1, 1, 0)); // ch1 over ch3
      tbl.push_back(mk(1, 4'b1000, 0, 0, 4'b1111, 4'b0000, 12'h123, 12'h0F0, 1, 3, 0)); // ch3 alone
      tbl.push_back(mk(1, 4'b1111, 1, 0, 4'b1111, 4'b0000, 12'h456, 12'h000, 0, 0, 0)); // blank override
      tbl.push_back(mk(1, 4'b1111, 0, 0, 4'b1111, 4'b0000, 12'h456, 12'h00F, 1, 0, 0)); // ch0 top
      tbl.push_back(mk(1, 4'b0100, 0, 0, 4'b1111, 4'b0000, 12'h456, 12'h555, 1, 2, 0)); // ch2
      tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b1111, 4'b0000, 12'h456, 12'h456, 0, 0, 0)); // bg
      foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

      // frame-boundary masking: mask change mid-frame has no effect
      seq(1, 0, 4'b0001, 4'b1110, 4'b0000, 12'h00F, 1, 0, 0, "mask_midframe");
      seq(1, 1, 4'b0001, 4'b1110, 4'b0000, 12'h00F, 1, 0, 0, "mask_fs_pixel");   // fcnt 0->1
      seq(1, 0, 4'b0001, 4'b1110, 4'b0000, 12'h456, 0, 0, 0, "mask_applied");
      seq(1, 0, 4'b0011, 4'b1110, 4'b0000, 12'hF00, 1, 1, 0, "mask_next_ch");

      // load en=all, flash ch0; this frame_start wraps fcnt and sets phase=1
      seq(1, 1, 4'b0001, 4'b1111, 4'b0001, 12'h456, 0, 0, 1, "load_flash");
      seq(1, 0, 4'b0001, 4'b1111, 4'b0001, 12'h456, 0, 0, 1, "flash_hidden0");
      seq(1, 1, 4'b0001, 4'b1111, 4'b0001, 12'h456, 0, 0, 1, "flash_hidden1");  // fcnt ->1
      seq(1, 0, 4'b0001, 4'b1111, 4'b0001, 12'h456, 0, 0, 1, "flash_hidden2");
      seq(1, 1, 4'b0001, 4'b1111, 4'b0001, 12'h456, 0, 0, 0, "flash_toggle0");  // phase ->0
      seq(1, 0, 4'b0001, 4'b1111, 4'b0001, 12'h00F, 1, 0, 0, "flash_shown0");
      seq(1, 1, 4'b0001, 4'b1111, 4'b0001, 12'h00F, 1, 0, 0, "flash_shown1");   // fcnt ->1
      seq(1, 0, 4'b0001, 4'b1111, 4'b0001, 12'h00F, 1, 0, 0, "flash_shown2");
      seq(1, 1, 4'b0001, 4'b1111, 4'b0001, 12'h00F, 1, 0, 1, "flash_toggle1");  // phase ->1
      seq(1, 0, 4'b0001, 4'b1111, 4'b0001, 12'h456, 0, 0, 1, "flash_hidden3");
      seq(1, 0, 4'b0011, 4'b1111, 4'b0001, 12'hF00, 1, 1, 1, "flash_fallthru");

      // reset during flash: phase=1, fcnt=1, reset together with frame_start
      seq(1, 1, 4'b0001, 4'b1111, 4'b0001, 12'h456, 0, 0, 1, "pre_rst_fs");     // fcnt ->1
      seq(0, 1, 4'b0001, 4'b0000, 4'b1111, 12'h000, 0, 0, 0, "rst_fs");
      seq(1, 0, 4'b0001, 4'b0000, 4'b1111, 12'h00F, 1, 0, 0, "post_rst_masks");
      seq(1, 1, 4'b0001, 4'b1111, 4'b0000, 12'h00F, 1, 0, 0, "post_rst_fs0");   // fcnt 0->1
      seq(1, 1, 4'b0001, 4'b1111, 4'b0000, 12'h00F, 1, 0, 1, "post_rst_fs1");   // wrap, phase 1
      seq(1, 0, 4'b0001, 4'b1111, 4'b0000, 12'h00F, 1, 0, 1, "no_flash_act");

      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, want completion");
      $fatal(1, "watchdog");
   end
endmodule
